// File: rtl/aibnd_str_rxclkmon.sv
// Receive strobe monitor: synchronizes the forwarded pad strobe, detects both
// edges and qualifies it as locked/lost in the local clock domain.
module aibnd_str_rxclkmon #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_EDGES  = 8,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vcc_aibnd,
  input  logic             vss_aibnd,
  input  logic             str_in,
  input  logic             enable,
  input  logic             clr_lost,
  output logic             str_active,
  output logic             str_lost,
  output logic             str_lost_sticky,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_t;

  localparam logic [7:0]       GAP_MAX = 8'(TIMEOUT - 1);
  localparam logic [7:0]       ACQ_MAX = 8'(LOCK_EDGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    s_prev_q, s_prev_d;
  logic [7:0]              gap_q, gap_d;
  logic [7:0]              acq_q, acq_d;
  logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic                    str_active_q, str_active_d;
  logic                    str_lost_q, str_lost_d;
  logic                    sticky_q, sticky_d;

  logic                    s_sync;
  logic                    edge_det;
  logic                    gap_run;
  logic                    timeout;
  logic                    unused_supply;

  // Supply pins carry no logic function.
  assign unused_supply = vcc_aibnd ^ vss_aibnd;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], str_in};
    s_sync   = sync_q[SYNC_STAGES-1];
    s_prev_d = s_sync;
    edge_det = s_sync ^ s_prev_q;
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    acq_d      = acq_q;
    edge_cnt_d = edge_cnt_q;

    gap_run = (state_q == ACQ) || (state_q == LOCKED);
    timeout = gap_run && (gap_q == GAP_MAX) && !edge_det;

    // Edge wins over timeout: a cycle with an edge always restarts the gap.
    if (gap_run) begin
      if (edge_det) begin
        gap_d = 8'd0;
      end else if (gap_q != GAP_MAX) begin
        gap_d = gap_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        gap_d      = 8'd0;
        acq_d      = 8'd0;
        edge_cnt_d = '0;
        state_d    = ACQ;
      end
      ACQ: begin
        if (edge_det) begin
          if (acq_q == ACQ_MAX) begin
            state_d = LOCKED;
            acq_d   = 8'd0;
          end else begin
            acq_d = acq_q + 8'd1;
          end
        end else if (timeout) begin
          acq_d = 8'd0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (edge_cnt_q != CNT_MAX) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOST: begin
        state_d = ACQ;
        acq_d   = 8'd0;
        gap_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!enable) begin
      state_d    = IDLE;
      gap_d      = 8'd0;
      acq_d      = 8'd0;
      edge_cnt_d = '0;
    end

    str_active_d = (state_d == LOCKED);
    str_lost_d   = (state_d == LOST);
    // Set is held across the whole LOST event so a coincident clear loses.
    sticky_d     = str_lost_d || (state_q == LOST) || (sticky_q && !clr_lost);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_prev_q     <= 1'b0;
      gap_q        <= 8'd0;
      acq_q        <= 8'd0;
      edge_cnt_q   <= '0;
      str_active_q <= 1'b0;
      str_lost_q   <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_prev_q     <= s_prev_d;
      gap_q        <= gap_d;
      acq_q        <= acq_d;
      edge_cnt_q   <= edge_cnt_d;
      str_active_q <= str_active_d;
      str_lost_q   <= str_lost_d;
      sticky_q     <= sticky_d;
    end
  end

  assign str_active      = str_active_q;
  assign str_lost        = str_lost_q;
  assign str_lost_sticky = sticky_q;
  assign edge_cnt        = edge_cnt_q;

endmodule

// File: tb/tb_aibnd_str_rxclkmon.sv
// Scoreboard bench for aibnd_str_rxclkmon: directed strobe patterns with
// cycle-tagged expected outputs checked by an independent monitor.
module tb_aibnd_str_rxclkmon;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             vcc_aibnd = 1'b1;
  logic             vss_aibnd = 1'b0;
  logic             str_in;
  logic             enable;
  logic             clr_lost;
  logic             str_active;
  logic             str_lost;
  logic             str_lost_sticky;
  logic [CNT_W-1:0] edge_cnt;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lost_pulses = 0;
  int base;

  typedef struct packed {
    int               cyc;
    logic [95:0]      tag;
    logic             a;
    logic             l;
    logic             s;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t sb[$];

  aibnd_str_rxclkmon #(
    .SYNC_STAGES(2),
    .LOCK_EDGES (8),
    .TIMEOUT    (16),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vcc_aibnd      (vcc_aibnd),
    .vss_aibnd      (vss_aibnd),
    .str_in         (str_in),
    .enable         (enable),
    .clr_lost       (clr_lost),
    .str_active     (str_active),
    .str_lost       (str_lost),
    .str_lost_sticky(str_lost_sticky),
    .edge_cnt       (edge_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic gotoCyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A toggle driven in cycle t shows as an edge in t+2 and on outputs in t+3.
  task automatic applyStimulus(input int t);
    gotoCyc(t);
    str_in = ~str_in;
  endtask

  task automatic expectAt(input int t, input logic [95:0] tag, input logic a,
                          input logic l, input logic s, input logic [CNT_W-1:0] c);
    exp_t e;
    e.cyc = t;
    e.tag = tag;
    e.a   = a;
    e.l   = l;
    e.s   = s;
    e.c   = c;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (str_active !== e.a || str_lost !== e.l || str_lost_sticky !== e.s || edge_cnt !== e.c) begin
      errors++;
      $display("[TB] FAIL %0s cyc=%0d got act=%b lost=%b sticky=%b cnt=%0d want act=%b lost=%b sticky=%b cnt=%0d",
               e.tag, cyc, str_active, str_lost, str_lost_sticky, edge_cnt, e.a, e.l, e.s, e.c);
    end
  endtask

  always @(negedge clk) begin : monitor
    int idx;
    if (str_lost === 1'b1) lost_pulses++;
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].cyc == cyc) begin
        checkOutput(sb[idx]);
        sb.delete(idx);
      end else if (sb[idx].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %0s expectation for cycle %0d never sampled", sb[idx].tag, sb[idx].cyc);
        sb.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    str_in   = 1'b0;
    clr_lost = 1'b0;

    // Strobe wiggles while reset is held: outputs must stay at zero.
    gotoCyc(2);
    for (int k = 0; k < 6; k++) begin
      expectAt(cyc, "reset_hold", 1'b0, 1'b0, 1'b0, 4'd0);
      str_in = ~str_in;
      gotoCyc(cyc + 1);
    end
    gotoCyc(11);
    reset = 1'b0;
    expectAt(11, "reset_rel", 1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(12, "reset_rel1", 1'b0, 1'b0, 1'b0, 4'd0);
    gotoCyc(13);
    enable = 1'b1;
    base = 15;

    expectAt(base + 16,  "pre_lock",    1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(base + 17,  "lock",        1'b1, 1'b0, 1'b0, 4'd0);
    expectAt(base + 32,  "gap15",       1'b1, 1'b0, 1'b0, 4'd0);
    expectAt(base + 33,  "gap15_edge",  1'b1, 1'b0, 1'b0, 4'd1);
    expectAt(base + 48,  "gap16_pre",   1'b1, 1'b0, 1'b0, 4'd1);
    expectAt(base + 49,  "lost",        1'b0, 1'b1, 1'b1, 4'd1);
    expectAt(base + 50,  "lost_after",  1'b0, 1'b0, 1'b1, 4'd1);
    expectAt(base + 68,  "relock_pre",  1'b0, 1'b0, 1'b1, 4'd1);
    expectAt(base + 69,  "relock",      1'b1, 1'b0, 1'b1, 4'd1);
    expectAt(base + 97,  "cnt14",       1'b1, 1'b0, 1'b1, 4'd14);
    expectAt(base + 99,  "cnt15",       1'b1, 1'b0, 1'b1, 4'd15);
    expectAt(base + 111, "cnt_sat",     1'b1, 1'b0, 1'b1, 4'd15);
    expectAt(base + 112, "clr_pre",     1'b1, 1'b0, 1'b1, 4'd15);
    expectAt(base + 113, "clr",         1'b1, 1'b0, 1'b0, 4'd15);
    expectAt(base + 126, "lost2_pre",   1'b1, 1'b0, 1'b0, 4'd15);
    expectAt(base + 127, "lost2",       1'b0, 1'b1, 1'b1, 4'd15);
    expectAt(base + 128, "set_wins",    1'b0, 1'b0, 1'b1, 4'd15);
    expectAt(base + 129, "clr_late",    1'b0, 1'b0, 1'b0, 4'd15);
    expectAt(base + 157, "acq_tmo",     1'b0, 1'b0, 1'b0, 4'd15);
    expectAt(base + 164, "acq_no_lock", 1'b0, 1'b0, 1'b0, 4'd15);
    expectAt(base + 173, "acq_pre",     1'b0, 1'b0, 1'b0, 4'd15);
    expectAt(base + 174, "acq_lock",    1'b1, 1'b0, 1'b0, 4'd15);
    expectAt(base + 176, "en_pre",      1'b1, 1'b0, 1'b0, 4'd15);
    expectAt(base + 177, "en_drop_lk",  1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(base + 190, "en_drop_acq", 1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(base + 205, "acq_cleared", 1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(base + 210, "final_pre",   1'b0, 1'b0, 1'b0, 4'd0);
    expectAt(base + 211, "final_lock",  1'b1, 1'b0, 1'b0, 4'd0);

    for (int k = 0; k < 8; k++)  applyStimulus(base + 2 * k);
    applyStimulus(base + 30);
    for (int k = 0; k < 8; k++)  applyStimulus(base + 52 + 2 * k);
    for (int k = 0; k < 20; k++) applyStimulus(base + 70 + 2 * k);

    gotoCyc(base + 112);
    clr_lost = 1'b1;
    gotoCyc(base + 113);
    clr_lost = 1'b0;
    gotoCyc(base + 127);
    clr_lost = 1'b1;
    gotoCyc(base + 129);
    clr_lost = 1'b0;

    for (int k = 0; k < 5; k++) applyStimulus(base + 130 + 2 * k);
    for (int k = 0; k < 8; k++) applyStimulus(base + 157 + 2 * k);

    gotoCyc(base + 176);
    enable = 1'b0;
    gotoCyc(base + 180);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(base + 182 + 2 * k);
    gotoCyc(base + 189);
    enable = 1'b0;
    gotoCyc(base + 192);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(base + 194 + 2 * k);

    gotoCyc(base + 215);
    @(negedge clk);
    #1;

    checks++;
    if (lost_pulses != 2) begin
      errors++;
      $display("[TB] FAIL lost_pulse_count got %0d want 2", lost_pulses);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
